// File: rtl/usb_in_pkt_ctrl.sv
// usb_in_pkt_ctrl: IN-endpoint packetizer between the TX packet FIFO and the
// USB SIE transmit interface. It sizes each packet on an IN token, arms the
// FIFO, forwards bytes as the SIE pops them, commits on ACK, and keeps the
// packet for a byte-exact retransmit on timeout.
// Optional feature: define UAC_TX_ZLP_EN to send a zero-length packet after
// an ACKed full-size packet that left the FIFO empty.
module usb_in_pkt_ctrl #(
    parameter int unsigned ASIZE   = 9,
    parameter int unsigned MAX_PKT = 512
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             in_token,
    input  logic             tx_pop,
    input  logic             tx_ack,
    input  logic             tx_timeout,
    input  logic [ASIZE:0]   fifo_wrnum,
    input  logic             fifo_empty,
    input  logic [7:0]       fifo_odata,
    output logic             fifo_read,
    output logic             fifo_txact,
    output logic             fifo_pktfin,
    output logic [7:0]       tx_dat,
    output logic [ASIZE:0]   tx_len,
    output logic             tx_cork,
    output logic             busy
);

    localparam int unsigned   LW      = ASIZE + 1;
    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_PKT);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARM      = 2'd1,
        S_SEND     = 2'd2,
        S_WAIT_ACK = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [LW-1:0] r_byte_cnt;
    logic [LW-1:0] r_tx_len;
    logic [LW-1:0] w_size;
    logic          r_tx_cork;
    logic          r_active;
    logic          r_retry_pend;
    logic          w_zlp_pend;
    logic          w_accept;
    logic          w_fifo_read;
    logic          w_pktfin;
    logic          w_unused;

    // Packet sizing uses the fill level only; the empty flag is redundant here.
    assign w_unused = fifo_empty;

    // Packet size when fresh data is offered: min(fill level, max payload).
    assign w_size = (fifo_wrnum > MAX_LEN) ? MAX_LEN : fifo_wrnum;

    assign fifo_read   = w_fifo_read;
    assign fifo_pktfin = w_pktfin;
    assign fifo_txact  = r_active;
    assign busy        = r_active;
    assign tx_dat      = fifo_odata;
    assign tx_len      = r_tx_len;
    assign tx_cork     = r_tx_cork;

    // State register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode plus the same-cycle FIFO read and commit strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_fifo_read = 1'b0;
        w_pktfin    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (in_token && !r_tx_cork) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ARM;
                end
            end
            S_ARM: begin
                w_state_nxt = (r_tx_len == '0) ? S_WAIT_ACK : S_SEND;
            end
            S_SEND: begin
                w_fifo_read = tx_pop && (r_byte_cnt < r_tx_len);
                if (tx_timeout) begin
                    w_state_nxt = S_IDLE;
                end else if (w_fifo_read && (r_byte_cnt == r_tx_len - LW'(1))) begin
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (tx_ack) begin
                    w_pktfin    = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (tx_timeout) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Packet length, byte counter, cork, retry flag and transfer-active level.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_tx_len     <= '0;
            r_byte_cnt   <= '0;
            r_tx_cork    <= 1'b0;
            r_retry_pend <= 1'b0;
            r_active     <= 1'b0;
        end else begin
            r_active <= (w_state_nxt != S_IDLE);

            // Cork re-evaluates only in IDLE; while busy new tokens are ignored anyway.
            if (r_state == S_IDLE) begin
                r_tx_cork <= (fifo_wrnum == '0) && !r_retry_pend && !w_zlp_pend;
            end else begin
                r_tx_cork <= 1'b1;
            end

            // A retransmit reuses the latched length; a pending ZLP sends zero bytes.
            if (w_accept) begin
                if (r_retry_pend) begin
                    r_tx_len <= r_tx_len;
                end else if (w_zlp_pend) begin
                    r_tx_len <= '0;
                end else begin
                    r_tx_len <= w_size;
                end
            end

            if (r_state == S_ARM) begin
                r_byte_cnt <= '0;
            end else if (w_fifo_read) begin
                r_byte_cnt <= r_byte_cnt + LW'(1);
            end

            if ((r_state == S_SEND) && tx_timeout) begin
                r_retry_pend <= 1'b1;
            end else if (r_state == S_WAIT_ACK) begin
                if (tx_ack) begin
                    r_retry_pend <= 1'b0;
                end else if (tx_timeout) begin
                    r_retry_pend <= 1'b1;
                end
            end
        end
    end

`ifdef UAC_TX_ZLP_EN
    logic r_zlp_pend;

    // A full-size packet that drained the FIFO must be terminated by a ZLP.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_zlp_pend <= 1'b0;
        end else if ((r_state == S_WAIT_ACK) && tx_ack) begin
            r_zlp_pend <= (r_tx_len == MAX_LEN) && (fifo_wrnum == '0);
        end
    end

    assign w_zlp_pend = r_zlp_pend;
`else
    assign w_zlp_pend = 1'b0;
`endif

endmodule
